// File: rtl/link_readburst_arb_pkg.sv
// Shared types and helpers for the readburst link arbiter.
package link_readburst_arb_pkg;

    localparam int unsigned DW_LEN_W = 2;
    localparam int unsigned BL_LEN_W = 4;

    typedef struct packed {
        logic [DW_LEN_W-1:0] dword_length;
        logic [BL_LEN_W-1:0] byte_length;
    } burst_len_t;

    // Channel index width, never narrower than one bit
    function automatic int unsigned ch_w_f(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/link_readburst_arb_if.sv
// Requester-side and memory-side readburst signals of the link arbiter.
interface link_readburst_arb_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 96
);
    import link_readburst_arb_pkg::*;

    localparam int unsigned CH_W = ch_w_f(CHANNELS);

    logic [CHANNELS-1:0]          req_readburst_do;
    logic [CHANNELS-1:0]          req_readburst_done;
    logic [CHANNELS*ADDR_W-1:0]   req_readburst_address;
    logic [CHANNELS*DW_LEN_W-1:0] req_readburst_dword_length;
    logic [CHANNELS*BL_LEN_W-1:0] req_readburst_byte_length;
    logic [DATA_W-1:0]            req_readburst_data;

    logic                         resp_readburst_do;
    logic                         resp_readburst_done;
    logic [ADDR_W-1:0]            resp_readburst_address;
    logic [DW_LEN_W-1:0]          resp_readburst_dword_length;
    logic [BL_LEN_W-1:0]          resp_readburst_byte_length;
    logic [DATA_W-1:0]            resp_readburst_data;
    logic [CH_W-1:0]              resp_readburst_channel;

    modport slave (
        input  req_readburst_do, req_readburst_address, req_readburst_dword_length,
               req_readburst_byte_length, resp_readburst_done, resp_readburst_data,
        output req_readburst_done, req_readburst_data, resp_readburst_do,
               resp_readburst_address, resp_readburst_dword_length,
               resp_readburst_byte_length, resp_readburst_channel
    );

    modport master (
        output req_readburst_do, req_readburst_address, req_readburst_dword_length,
               req_readburst_byte_length, resp_readburst_done, resp_readburst_data,
        input  req_readburst_done, req_readburst_data, resp_readburst_do,
               resp_readburst_address, resp_readburst_dword_length,
               resp_readburst_byte_length, resp_readburst_channel
    );

endinterface

// File: rtl/link_readburst_rr_arbiter.sv
// Combinational round-robin pick: first eligible index after last_grant, wrapping.
module link_readburst_rr_arbiter
    import link_readburst_arb_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    localparam int unsigned CH_W    = ch_w_f(CHANNELS)
) (
    input  logic [CHANNELS-1:0] eligible,
    input  logic [CH_W-1:0]     last_grant,
    output logic                grant_valid,
    output logic [CH_W-1:0]     grant_idx
);

    int unsigned cand;

    // Walk from farthest to nearest so the nearest eligible index wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = CHANNELS; k >= 1; k--) begin
            cand = (32'(last_grant) + k) % CHANNELS;
            if (eligible[CH_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
    end

endmodule

// File: rtl/link_readburst_arb.sv
// Full-save readburst link: captures per-channel requests and serves them round-robin on one port.
module link_readburst_arb
    import link_readburst_arb_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 96,
    parameter bit          REG_RESP = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    link_readburst_arb_if.slave  bus
);

    localparam int unsigned CH_W = ch_w_f(CHANNELS);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] pending_q, eligible, req_done, done_vec;
    logic [ADDR_W-1:0]   live_addr  [CHANNELS];
    logic [ADDR_W-1:0]   saved_addr [CHANNELS];
    burst_len_t          live_len   [CHANNELS];
    burst_len_t          saved_len  [CHANNELS];
    logic                grant_valid, burst_done, resp_do_q;
    logic [CH_W-1:0]     grant_idx, grant_q, grant_d, last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    burst_len_t          len_q, len_d;

    assign burst_done = (state_q == ST_BUSY) && bus.resp_readburst_done;
    // A channel whose completion is pulsing is not offered again in that cycle
    assign eligible   = (pending_q | bus.req_readburst_do) & ~req_done;

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        logic              pend;
        logic [ADDR_W-1:0] s_addr;
        burst_len_t        s_len;

        assign live_addr[i]             = bus.req_readburst_address[i*ADDR_W +: ADDR_W];
        assign live_len[i].dword_length = bus.req_readburst_dword_length[i*DW_LEN_W +: DW_LEN_W];
        assign live_len[i].byte_length  = bus.req_readburst_byte_length[i*BL_LEN_W +: BL_LEN_W];

        // Fields are sampled only on the first do cycle of a request
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend   <= 1'b0;
                s_addr <= '0;
                s_len  <= '0;
            end else if (req_done[i]) begin
                pend   <= 1'b0;
            end else if (bus.req_readburst_do[i] && !pend) begin
                pend   <= 1'b1;
                s_addr <= live_addr[i];
                s_len  <= live_len[i];
            end
        end

        assign pending_q[i]  = pend;
        assign saved_addr[i] = s_addr;
        assign saved_len[i]  = s_len;
    end

    link_readburst_rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .eligible    (eligible),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next state; a request granted in its capture cycle takes the live fields
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_BUSY;
                    grant_d = grant_idx;
                    if (pending_q[grant_idx]) begin
                        addr_d = saved_addr[grant_idx];
                        len_d  = saved_len[grant_idx];
                    end else begin
                        addr_d = live_addr[grant_idx];
                        len_d  = live_len[grant_idx];
                    end
                end
            end
            ST_BUSY: begin
                if (bus.resp_readburst_done) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= CH_W'(CHANNELS - 1);
            addr_q    <= '0;
            len_q     <= '0;
            resp_do_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            resp_do_q <= (state_d == ST_BUSY);
        end
    end

    assign done_vec = burst_done ? (CHANNELS'(1) << grant_q) : '0;

    if (REG_RESP) begin : g_reg_resp
        logic [CHANNELS-1:0] done_q;
        logic [DATA_W-1:0]   data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                done_q <= '0;
                data_q <= '0;
            end else begin
                done_q <= done_vec;
                if (burst_done) data_q <= bus.resp_readburst_data;
            end
        end

        assign req_done               = done_q;
        assign bus.req_readburst_data = data_q;
    end else begin : g_pass_resp
        assign req_done               = done_vec;
        assign bus.req_readburst_data = bus.resp_readburst_data;
    end

    assign bus.req_readburst_done          = req_done;
    assign bus.resp_readburst_do           = resp_do_q;
    assign bus.resp_readburst_address      = addr_q;
    assign bus.resp_readburst_dword_length = len_q.dword_length;
    assign bus.resp_readburst_byte_length  = len_q.byte_length;
    assign bus.resp_readburst_channel      = grant_q;

endmodule

// File: tb/tb_link_readburst_arb.sv
// Directed bench for link_readburst_arb: passthrough and registered-response instances.
module tb_link_readburst_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  dw;
        logic [3:0]  bl;
        logic        ch;
    } exp_t;

    exp_t exp_q[$];

    link_readburst_arb_if #(.CHANNELS(2), .ADDR_W(32), .DATA_W(96)) a ();
    link_readburst_arb_if #(.CHANNELS(2), .ADDR_W(32), .DATA_W(96)) b ();

    link_readburst_arb #(.CHANNELS(2), .ADDR_W(32), .DATA_W(96), .REG_RESP(1'b0)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (a)
    );
    link_readburst_arb #(.CHANNELS(2), .ADDR_W(32), .DATA_W(96), .REG_RESP(1'b1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic [31:0] addr, input logic [1:0] dw,
                           input logic [3:0] bl, input bit push);
        exp_t e;
        a.req_readburst_do[ch]               = 1'b1;
        a.req_readburst_address[ch*32 +: 32] = addr;
        a.req_readburst_dword_length[ch*2 +: 2] = dw;
        a.req_readburst_byte_length[ch*4 +: 4]  = bl;
        if (push) begin
            e.addr = addr; e.dw = dw; e.bl = bl; e.ch = ch[0];
            exp_q.push_back(e);
        end
    endtask

    // Wait for the next grant on bus a, check it against the scoreboard, complete it
    task automatic serve(input int exp_lat, input logic [95:0] data);
        int         n;
        exp_t       e;
        logic [1:0] onehot;
        n = 0;
        while (a.resp_readburst_do !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk("grant_latency", 128'(n), 128'(exp_lat));
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_underflow observed=0 expected=1");
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("resp_address", a.resp_readburst_address, e.addr);
        chk("resp_dword_length", a.resp_readburst_dword_length, e.dw);
        chk("resp_byte_length", a.resp_readburst_byte_length, e.bl);
        chk("resp_channel", a.resp_readburst_channel, e.ch);
        tick();
        tick();
        chk("resp_fields_held", a.resp_readburst_address, e.addr);
        a.resp_readburst_done = 1'b1;
        a.resp_readburst_data = data;
        #1;
        onehot = 2'b01 << e.ch;
        chk("req_done_pulse", a.req_readburst_done, onehot);
        chk("req_data_pass", a.req_readburst_data, data);
        tick();
        a.resp_readburst_done = 1'b0;
        a.req_readburst_do[e.ch] = 1'b0;
        #1;
        chk("req_done_clear", a.req_readburst_done, 2'b00);
        chk("resp_do_drop", a.resp_readburst_do, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        a.req_readburst_do = '0; a.req_readburst_address = '0;
        a.req_readburst_dword_length = '0; a.req_readburst_byte_length = '0;
        a.resp_readburst_done = 1'b0; a.resp_readburst_data = '0;
        b.req_readburst_do = '0; b.req_readburst_address = '0;
        b.req_readburst_dword_length = '0; b.req_readburst_byte_length = '0;
        b.resp_readburst_done = 1'b0; b.resp_readburst_data = '0;

        #12;
        chk("rst_resp_do", a.resp_readburst_do, 1'b0);
        chk("rst_req_done", a.req_readburst_done, 2'b00);
        chk("rst_resp_address", a.resp_readburst_address, 32'h0);
        chk("rst_resp_dword", a.resp_readburst_dword_length, 2'b00);
        chk("rst_resp_channel", a.resp_readburst_channel, 1'b0);
        chk("rst_reg_req_done", b.req_readburst_done, 2'b00);
        chk("rst_reg_req_data", b.req_readburst_data, 96'h0);
        rst_n = 1'b1;
        tick();

        // Single request on ch0
        set_req(0, 32'h1000, 2'd2, 4'd12, 1'b1);
        #1;
        chk("no_same_cycle_grant", a.resp_readburst_do, 1'b0);
        serve(1, 96'h1111_2222_3333_4444_5555_6666);

        // Both at once after ch0 was last: ch1 then ch0
        tick();
        set_req(1, 32'h2100, 2'd1, 4'd8, 1'b1);
        set_req(0, 32'h1100, 2'd3, 4'd4, 1'b1);
        serve(1, 96'hA5A5_0000_0000_0000_0000_0001);
        serve(1, 96'h5A5A_0000_0000_0000_0000_0002);

        // Fields changing after capture are ignored
        tick();
        set_req(1, 32'h2000, 2'd0, 4'd5, 1'b1);
        tick();
        set_req(1, 32'h3000, 2'd2, 4'd9, 1'b0);
        #1;
        serve(0, 96'hDEAD_BEEF_0000_0000_0000_0003);

        // Both at once after ch1 was last: ch0 then ch1
        tick();
        set_req(0, 32'h1200, 2'd1, 4'd3, 1'b1);
        set_req(1, 32'h2200, 2'd2, 4'd7, 1'b1);
        serve(1, 96'h0123_4567_89AB_CDEF_0000_0004);
        serve(1, 96'hFEDC_BA98_7654_3210_0000_0005);

        // Requester drops do early; the saved request still completes
        tick();
        set_req(0, 32'h4000, 2'd3, 4'd15, 1'b1);
        tick();
        a.req_readburst_do[0] = 1'b0;
        a.req_readburst_address[31:0] = 32'hFFFF_FFFF;
        #1;
        serve(0, 96'h0000_0000_0000_0000_0000_0006);

        // Stray resp_done while idle
        tick();
        a.resp_readburst_done = 1'b1;
        #1;
        chk("idle_done_ignored", a.req_readburst_done, 2'b00);
        tick();
        a.resp_readburst_done = 1'b0;
        #1;
        chk("idle_stays_idle", a.resp_readburst_do, 1'b0);
        chk("sb_empty_mid", 128'(exp_q.size()), 128'd0);

        // Registered response instance
        tick();
        b.req_readburst_do = 2'b01;
        b.req_readburst_address[31:0] = 32'h5000;
        b.req_readburst_dword_length[1:0] = 2'd1;
        b.req_readburst_byte_length[3:0] = 4'd6;
        #1;
        chk("reg_no_same_cycle_grant", b.resp_readburst_do, 1'b0);
        tick();
        chk("reg_grant", b.resp_readburst_do, 1'b1);
        chk("reg_resp_address", b.resp_readburst_address, 32'h5000);
        chk("reg_resp_channel", b.resp_readburst_channel, 1'b0);
        tick();
        b.resp_readburst_done = 1'b1;
        b.resp_readburst_data = {12{8'hAB}};
        #1;
        chk("reg_done_not_same_cycle", b.req_readburst_done, 2'b00);
        tick();
        b.resp_readburst_done = 1'b0;
        b.resp_readburst_data = '0;
        #1;
        chk("reg_done_pulse", b.req_readburst_done, 2'b01);
        chk("reg_data", b.req_readburst_data, {12{8'hAB}});
        chk("reg_no_regrant_t1", b.resp_readburst_do, 1'b0);
        tick();
        chk("reg_done_single", b.req_readburst_done, 2'b00);
        chk("reg_data_hold", b.req_readburst_data, {12{8'hAB}});
        chk("reg_no_regrant_t2", b.resp_readburst_do, 1'b0);
        tick();
        chk("reg_new_request_granted", b.resp_readburst_do, 1'b1);
        b.resp_readburst_done = 1'b1;
        tick();
        b.resp_readburst_done = 1'b0;
        b.req_readburst_do = 2'b00;
        tick();
        tick();
        chk("reg_quiet", b.resp_readburst_do, 1'b0);

        // Reset while busy drops the burst
        tick();
        set_req(1, 32'h6000, 2'd1, 4'd2, 1'b0);
        tick();
        chk("pre_reset_busy", a.resp_readburst_do, 1'b1);
        rst_n = 1'b0;
        a.req_readburst_do = 2'b00;
        #1;
        chk("reset_resp_do", a.resp_readburst_do, 1'b0);
        chk("reset_resp_address", a.resp_readburst_address, 32'h0);
        chk("reset_resp_channel", a.resp_readburst_channel, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", a.resp_readburst_do, 1'b0);
        tick();
        chk("post_reset_no_stale", a.resp_readburst_do, 1'b0);
        set_req(0, 32'h7000, 2'd2, 4'd12, 1'b1);
        serve(1, 96'h7777_0000_0000_0000_0000_0007);
        chk("sb_empty_end", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
